// File: rtl/alu_funct_pkg.sv
// Shared ALU-control function codes and the multiplier state encoding.
// The ALU control block is expected to move onto these same constants so
// that the producer and consumer sides of the function-code bus agree.
package alu_funct_pkg;

  localparam logic [5:0] FN_AND       = 6'b100100;
  localparam logic [5:0] FN_OR        = 6'b100101;
  localparam logic [5:0] FN_ADD       = 6'b100000;
  localparam logic [5:0] FN_SUB       = 6'b100010;
  localparam logic [5:0] FN_SLT       = 6'b101010;
  localparam logic [5:0] FN_SRL       = 6'b000010;
  localparam logic [5:0] FN_MULTU     = 6'b011001;
  localparam logic [5:0] FN_MULT      = 6'b011000;
  localparam logic [5:0] FN_MFHI      = 6'b010000;
  localparam logic [5:0] FN_MFLO      = 6'b010010;
  localparam logic [5:0] FN_OPEN_HILO = 6'b111111;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_LOAD = 2'd1,
    MUL_RUN  = 2'd2,
    MUL_DONE = 2'd3
  } mul_state_t;

endpackage

// File: rtl/multu_hilo_unit_radix4_step.sv
// One radix-4 partial-product accumulation: adds 0, 1, 2 or 3 times the
// (already shifted) multiplicand to the running product.
module radix4_step #(
  parameter int PW = 64
) (
  input  logic [PW-1:0] prod_i,
  input  logic [PW-1:0] mcand_i,
  input  logic [1:0]    d_i,
  output logic [PW-1:0] prod_o
);

  // Select the digit multiple and accumulate; wraps modulo 2^PW.
  always_comb begin
    prod_o = prod_i;
    case (d_i)
      2'd0: prod_o = prod_i;
      2'd1: prod_o = prod_i + mcand_i;
      2'd2: prod_o = prod_i + (mcand_i << 1);
      2'd3: prod_o = prod_i + (mcand_i << 1) + mcand_i;
      default: prod_o = prod_i;
    endcase
  end

endmodule

// File: rtl/multu_hilo_unit.sv
// Sequential radix-4 unsigned multiplier with the HI/LO register pair.
// Listens to the ALU-control function code, computes the 64-bit product in
// ITER cycles, commits it on OPEN_HILO and serves MFHI/MFLO reads.
// Optional build macro: MULTU_HILO_SIGNED_EN adds signed MULT support.
module multu_hilo_unit
  import alu_funct_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH / 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       signal,
  input  logic             mulreset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done
);

  localparam int PW = 2 * WIDTH;
  localparam int IW = $clog2(ITER + 1);

  mul_state_t       state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [IW-1:0]    iter_q, iter_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             sign_q, sign_d;

  logic             isMul;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;
  logic             capSign;
  logic [PW-1:0]    stepProd;

`ifdef MULTU_HILO_SIGNED_EN
  logic isSigned;

  // MULT shares the MULTU protocol; its operands become magnitudes at
  // capture and the result sign is remembered for the final negation.
  always_comb begin
    isMul    = (signal == FN_MULTU) || (signal == FN_MULT);
    isSigned = (signal == FN_MULT);
    magA     = (isSigned && dataA[WIDTH-1]) ? (~dataA + 1'b1) : dataA;
    magB     = (isSigned && dataB[WIDTH-1]) ? (~dataB + 1'b1) : dataB;
    capSign  = isSigned && (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
  end
`else
  // Unsigned-only build: MULT is just an unknown code here.
  always_comb begin
    isMul   = (signal == FN_MULTU);
    magA    = dataA;
    magB    = dataB;
    capSign = 1'b0;
  end
`endif

  radix4_step #(.PW(PW)) u_step (
    .prod_i  (prod_q),
    .mcand_i (mcand_q),
    .d_i     (mplier_q[1:0]),
    .prod_o  (stepProd)
  );

  // Next-state logic: operand capture, iteration, abort/restart and commit.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    iter_d   = iter_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    sign_d   = sign_q;

    case (state_q)
      MUL_IDLE: begin
        if (isMul && mulreset) begin
          mcand_d  = {{WIDTH{1'b0}}, magA};
          mplier_d = magB;
          prod_d   = '0;
          iter_d   = '0;
          sign_d   = capSign;
          state_d  = MUL_LOAD;
        end
      end

      MUL_LOAD: begin
        if (isMul && mulreset) begin
          mcand_d  = {{WIDTH{1'b0}}, magA};
          mplier_d = magB;
          prod_d   = '0;
          iter_d   = '0;
          sign_d   = capSign;
        end else if (isMul) begin
          iter_d  = '0;
          state_d = MUL_RUN;
        end else if (signal != FN_OPEN_HILO) begin
          state_d = MUL_IDLE;
        end
      end

      // An OPEN_HILO that arrives early is treated as a no-op: iteration
      // carries on so the controller's later OPEN_HILO still commits.
      MUL_RUN: begin
        if (isMul && mulreset) begin
          mcand_d  = {{WIDTH{1'b0}}, magA};
          mplier_d = magB;
          prod_d   = '0;
          iter_d   = '0;
          sign_d   = capSign;
          state_d  = MUL_LOAD;
        end else if (isMul || (signal == FN_OPEN_HILO)) begin
          prod_d   = stepProd;
          mcand_d  = mcand_q << 2;
          mplier_d = mplier_q >> 2;
          iter_d   = iter_q + IW'(1);
          if (iter_q == IW'(ITER - 1)) begin
            prod_d  = sign_q ? (~stepProd + 1'b1) : stepProd;
            state_d = MUL_DONE;
          end
        end else begin
          state_d = MUL_IDLE;
        end
      end

      MUL_DONE: begin
        if (signal == FN_OPEN_HILO) begin
          hi_d    = prod_q[PW-1:WIDTH];
          lo_d    = prod_q[WIDTH-1:0];
          state_d = MUL_IDLE;
        end else if (isMul && mulreset) begin
          mcand_d  = {{WIDTH{1'b0}}, magA};
          mplier_d = magB;
          prod_d   = '0;
          iter_d   = '0;
          sign_d   = capSign;
          state_d  = MUL_LOAD;
        end
      end

      default: state_d = MUL_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any product and HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= MUL_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      iter_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      iter_q   <= iter_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      sign_q   <= sign_d;
    end
  end

  // Status flags and the HI/LO read mux onto the result bus.
  always_comb begin
    busy    = (state_q == MUL_LOAD) || (state_q == MUL_RUN);
    done    = (state_q == MUL_DONE);
    dataOut = '0;
    if (signal == FN_MFHI) begin
      dataOut = hi_q;
    end else if (signal == FN_MFLO) begin
      dataOut = lo_q;
    end
  end

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Directed bench for multu_hilo_unit: reset, products, timing of done,
// abort, ignored early OPEN_HILO, restart, async reset and MULT handling.
module tb_multu_hilo_unit;
  import alu_funct_pkg::*;

  logic        clk;
  logic        reset;
  logic [5:0]  signal;
  logic        mulreset;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  multu_hilo_unit #(.WIDTH(32), .ITER(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .signal   (signal),
    .mulreset (mulreset),
    .dataA    (dataA),
    .dataB    (dataB),
    .dataOut  (dataOut),
    .busy     (busy),
    .done     (done)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two edges with mulreset high; the next edge is the first with it low.
  task automatic load_operands(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    signal   = op;
    dataA    = a;
    dataB    = b;
    mulreset = 1'b1;
    tick();
    tick();
    mulreset = 1'b0;
  endtask

  // Advance until done rises or the budget expires; report edges used.
  task automatic wait_done(input int maxEdges, output int edges);
    edges = 0;
    while (!done && edges < maxEdges) begin
      tick();
      edges++;
    end
  endtask

  task automatic commit_hilo();
    signal = FN_OPEN_HILO;
    tick();
    signal = FN_ADD;
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    signal = FN_MFHI;
    #1;
    hi = dataOut;
    signal = FN_MFLO;
    #1;
    lo = dataOut;
    signal = FN_ADD;
  endtask

  task automatic test_reset();
    logic [31:0] hi, lo;
    reset = 1'b1;
    signal = FN_ADD;
    mulreset = 1'b0;
    dataA = '0;
    dataB = '0;
    #3;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags busy=%b done=%b want 0 0", busy, done);
    end
    read_hilo(hi, lo);
    vectors++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_hilo hi=%h lo=%h want 0 0", hi, lo);
    end
    signal = FN_ADD;
    #1;
    vectors++;
    if (dataOut !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_dataout got=%h want 0", dataOut);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int edges;
    logic [31:0] hi, lo;
    load_operands(FN_MULTU, 32'd3, 32'd5);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL basic_busy got=%b want 1", busy);
    end
    // first low edge moves LOAD->RUN, then 16 iteration edges
    wait_done(40, edges);
    vectors++;
    if (done !== 1'b1 || edges != 17) begin
      miscompares++;
      $display("[TB] FAIL basic_done_timing done=%b edges=%0d want 1 17", done, edges);
    end
    commit_hilo();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_after_commit done=%b busy=%b want 0 0", done, busy);
    end
    read_hilo(hi, lo);
    vectors++;
    if (hi !== 32'h0 || lo !== 32'h0000000F) begin
      miscompares++;
      $display("[TB] FAIL basic_3x5 hi=%h lo=%h want 00000000 0000000f", hi, lo);
    end
  endtask

  task automatic test_max();
    int edges;
    logic [31:0] hi, lo;
    load_operands(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(40, edges);
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL max_done got=%b want 1", done);
    end
    commit_hilo();
    read_hilo(hi, lo);
    vectors++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      miscompares++;
      $display("[TB] FAIL max_product hi=%h lo=%h want fffffffe 00000001", hi, lo);
    end
  endtask

  task automatic test_abort();
    int edges;
    logic [31:0] hi, lo;
    load_operands(FN_MULTU, 32'd3, 32'd5);
    wait_done(40, edges);
    commit_hilo();
    load_operands(FN_MULTU, 32'd7, 32'd9);
    tick();
    for (int i = 0; i < 5; i++) tick();
    signal = FN_ADD;
    tick();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_flags busy=%b done=%b want 0 0", busy, done);
    end
    signal = FN_MULTU;
    wait_done(20, edges);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_no_done done=%b want 0", done);
    end
    read_hilo(hi, lo);
    vectors++;
    if (hi !== 32'h0 || lo !== 32'h0000000F) begin
      miscompares++;
      $display("[TB] FAIL abort_hilo hi=%h lo=%h want 00000000 0000000f", hi, lo);
    end
  endtask

  task automatic test_open_ignored();
    int edges;
    logic [31:0] hi, lo;
    load_operands(FN_MULTU, 32'd6, 32'd7);
    tick();
    for (int i = 0; i < 8; i++) tick();
    signal = FN_OPEN_HILO;
    tick();
    signal = FN_MULTU;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL open_early_busy got=%b want 1", busy);
    end
    wait_done(40, edges);
    vectors++;
    if (done !== 1'b1 || edges != 7) begin
      miscompares++;
      $display("[TB] FAIL open_early_timing done=%b edges=%0d want 1 7", done, edges);
    end
    read_hilo(hi, lo);
    vectors++;
    if (lo !== 32'h0000000F || done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL open_early_uncommitted lo=%h done=%b want 0000000f 1", lo, done);
    end
    commit_hilo();
    read_hilo(hi, lo);
    vectors++;
    if (hi !== 32'h0 || lo !== 32'h0000002A) begin
      miscompares++;
      $display("[TB] FAIL open_early_commit hi=%h lo=%h want 00000000 0000002a", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    logic [31:0] hi, lo;
    load_operands(FN_MULTU, 32'd2, 32'd3);
    wait_done(40, edges);
    load_operands(FN_MULTU, 32'h0001_0000, 32'h0003_0005);
    wait_done(40, edges);
    vectors++;
    if (done !== 1'b1 || edges != 17) begin
      miscompares++;
      $display("[TB] FAIL restart_timing done=%b edges=%0d want 1 17", done, edges);
    end
    commit_hilo();
    read_hilo(hi, lo);
    vectors++;
    if (hi !== 32'h0000_0003 || lo !== 32'h0005_0000) begin
      miscompares++;
      $display("[TB] FAIL restart_product hi=%h lo=%h want 00000003 00050000", hi, lo);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] hi, lo;
    load_operands(FN_MULTU, 32'h1234_5678, 32'd9);
    tick();
    for (int i = 0; i < 4; i++) tick();
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL async_reset_flags busy=%b done=%b want 0 0", busy, done);
    end
    read_hilo(hi, lo);
    vectors++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL async_reset_hilo hi=%h lo=%h want 0 0", hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mult();
    int edges;
    logic [31:0] hi, lo;
    load_operands(FN_MULTU, 32'd3, 32'd5);
    wait_done(40, edges);
    commit_hilo();
    load_operands(FN_MULT, 32'hFFFF_FFFE, 32'd3);
    signal = FN_MULT;
    wait_done(40, edges);
`ifdef MULTU_HILO_SIGNED_EN
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mult_done got=%b want 1", done);
    end
    commit_hilo();
    read_hilo(hi, lo);
    vectors++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      miscompares++;
      $display("[TB] FAIL mult_signed hi=%h lo=%h want ffffffff fffffffa", hi, lo);
    end
`else
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mult_ignored_flags done=%b busy=%b want 0 0", done, busy);
    end
    commit_hilo();
    read_hilo(hi, lo);
    vectors++;
    if (hi !== 32'h0 || lo !== 32'h0000000F) begin
      miscompares++;
      $display("[TB] FAIL mult_ignored_hilo hi=%h lo=%h want 00000000 0000000f", hi, lo);
    end
`endif
  endtask

  // Scenario sequence followed by the one summary line.
  initial begin
    test_reset();
    test_basic();
    test_max();
    test_abort();
    test_open_ignored();
    test_back_to_back();
    test_async_reset();
    test_mult();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
